// File: rtl/run_controller_pkg.sv
// Shared types and defaults for the run controller: state encoding,
// default parameter values and the per-core release-point helper.
package run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam int DEF_NUM_CORES      = 1;
  localparam int DEF_RST_CYCLES     = 2;
  localparam int DEF_STAGGER        = 0;
  localparam int DEF_TIMEOUT_CYCLES = 400;
  localparam int DEF_CNT_W          = 32;

  // Hold-counter value at which a core's reset is released.
  function automatic int release_point(int rst_cycles, int stagger, int core);
    return rst_cycles + ((stagger != 0) ? core : 0);
  endfunction

endpackage

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with synchronous reset, synchronous clear and enable.
// Clear has priority over enable; the count sticks at all ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/run_controller.sv
// Run control for the processor: sequences reset into NUM_CORES cores,
// counts RUN cycles and ends the run on abort, all-halt or cycle budget.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int STAGGER        = DEF_STAGGER,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [NUM_CORES-1:0] Halt,
  output logic [NUM_CORES-1:0] CoreRst,
  output logic                 Running,
  output logic                 Done,
  output logic                 TimedOut,
  output logic                 Aborted,
  output logic [NUM_CORES-1:0] HaltSeen,
  output logic [CNT_W-1:0]     CycleCount
);

  localparam int LAST_REL = release_point(RST_CYCLES, STAGGER, NUM_CORES - 1);
  // Wide enough to hold LAST_REL + 1 without wrapping.
  localparam int HOLD_W = $clog2(LAST_REL + 2);
  localparam bit HAS_TIMEOUT = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_e           state_q, state_d;
  logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
  logic [NUM_CORES-1:0] halt_seen_q, halt_seen_d;
  logic                 timed_out_q, timed_out_d;
  logic                 aborted_q, aborted_d;

  logic                 run_clr, hold_en, cyc_en;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [CNT_W-1:0]     cycle_cnt;

  sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk   (Clk),
    .rst   (Rst),
    .clr   (run_clr),
    .en    (hold_en),
    .count (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (Clk),
    .rst   (Rst),
    .clr   (run_clr),
    .en    (cyc_en),
    .count (cycle_cnt)
  );

  // Value the hold counter takes on this edge while in RESET; releases are
  // decided against it so CoreRst falls on the edge the count is reached.
  assign hold_nxt = hold_cnt + HOLD_W'(1);

  // Next-state, per-core release and sticky-flag logic.
  always_comb begin
    state_d     = state_q;
    core_rst_d  = core_rst_q;
    halt_seen_d = halt_seen_q;
    timed_out_d = timed_out_q;
    aborted_d   = aborted_q;
    run_clr     = 1'b0;
    hold_en     = 1'b0;
    cyc_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        core_rst_d = '1;
        // Start beats a simultaneous Abort here; Abort alone is ignored.
        if (Start) begin
          state_d     = ST_RESET;
          run_clr     = 1'b1;
          halt_seen_d = '0;
          timed_out_d = 1'b0;
          aborted_d   = 1'b0;
        end
      end

      ST_RESET: begin
        if (Abort) begin
          state_d    = ST_DONE;
          aborted_d  = 1'b1;
          core_rst_d = '1;
        end else begin
          hold_en = 1'b1;
          for (int i = 0; i < NUM_CORES; i++) begin
            core_rst_d[i] = (hold_nxt < HOLD_W'(release_point(RST_CYCLES, STAGGER, i)));
          end
          if (hold_nxt == HOLD_W'(LAST_REL)) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        halt_seen_d = halt_seen_q | (Halt & ~core_rst_q);
        // Abort ends the run on this edge without counting the cycle.
        if (Abort) begin
          state_d    = ST_DONE;
          aborted_d  = 1'b1;
          core_rst_d = '1;
        end else begin
          cyc_en = 1'b1;
          if (&halt_seen_d) begin
            state_d    = ST_DONE;
            core_rst_d = '1;
          end else if (HAS_TIMEOUT && (cycle_cnt == TIMEOUT_LAST)) begin
            state_d     = ST_DONE;
            timed_out_d = 1'b1;
            core_rst_d  = '1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      core_rst_q  <= '1;
      halt_seen_q <= '0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_rst_q  <= core_rst_d;
      halt_seen_q <= halt_seen_d;
      timed_out_q <= timed_out_d;
      aborted_q   <= aborted_d;
    end
  end

  assign CoreRst    = core_rst_q;
  assign Running    = (state_q == ST_RUN);
  assign Done       = (state_q == ST_DONE);
  assign TimedOut   = timed_out_q;
  assign Aborted    = aborted_q;
  assign HaltSeen   = halt_seen_q;
  assign CycleCount = cycle_cnt;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: a table of single-cycle vectors,
// hand sequences for the multi-cycle corners, and randomized runs scored
// against an outcome model derived from the halt/abort/budget rules.
module tb_run_controller;

  localparam int NEVER = 1000;
  localparam int TO_B  = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: one core, RST_CYCLES=2, budget 400.
  logic        a_start, a_abort, a_running, a_done, a_to, a_ab;
  logic [0:0]  a_halt, a_core_rst, a_hs;
  logic [31:0] a_cnt;
  run_controller #(.NUM_CORES(1), .RST_CYCLES(2), .STAGGER(0),
                   .TIMEOUT_CYCLES(400), .CNT_W(32)) dut_a (
    .Clk(clk), .Rst(rst), .Start(a_start), .Abort(a_abort), .Halt(a_halt),
    .CoreRst(a_core_rst), .Running(a_running), .Done(a_done), .TimedOut(a_to),
    .Aborted(a_ab), .HaltSeen(a_hs), .CycleCount(a_cnt));

  // Instance B: four staggered cores, budget 60.
  logic       b_start, b_abort, b_running, b_done, b_to, b_ab;
  logic [3:0] b_halt, b_core_rst, b_hs;
  logic [7:0] b_cnt;
  run_controller #(.NUM_CORES(4), .RST_CYCLES(2), .STAGGER(1),
                   .TIMEOUT_CYCLES(TO_B), .CNT_W(8)) dut_b (
    .Clk(clk), .Rst(rst), .Start(b_start), .Abort(b_abort), .Halt(b_halt),
    .CoreRst(b_core_rst), .Running(b_running), .Done(b_done), .TimedOut(b_to),
    .Aborted(b_ab), .HaltSeen(b_hs), .CycleCount(b_cnt));

  // Instance C: 4-bit counter, no budget.
  logic       c_start, c_abort, c_running, c_done, c_to, c_ab;
  logic [0:0] c_halt, c_core_rst, c_hs;
  logic [3:0] c_cnt;
  run_controller #(.NUM_CORES(1), .RST_CYCLES(2), .STAGGER(0),
                   .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_c (
    .Clk(clk), .Rst(rst), .Start(c_start), .Abort(c_abort), .Halt(c_halt),
    .CoreRst(c_core_rst), .Running(c_running), .Done(c_done), .TimedOut(c_to),
    .Aborted(c_ab), .HaltSeen(c_hs), .CycleCount(c_cnt));

  typedef struct {
    logic        start, abort, halt;
    logic        core_rst, running, done, aborted, hs;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic ab, logic h, logic cr, logic run,
                              logic dn, logic abd, logic hs, int cnt);
    vec_t v;
    v.start = st; v.abort = ab; v.halt = h; v.core_rst = cr; v.running = run;
    v.done = dn; v.aborted = abd; v.hs = hs; v.cnt = 32'(cnt);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_start = 0; a_abort = 0; a_halt = '0;
    b_start = 0; b_abort = 0; b_halt = '0;
    c_start = 0; c_abort = 0; c_halt = '0;
  endtask

  // Pulse Start on A and count edges until its core leaves reset.
  task automatic a_start_run(output int edges);
    a_start = 1; step(); a_start = 0;
    edges = 1;
    while (a_core_rst !== 1'b0 && edges < 20) begin step(); edges++; end
    if (edges >= 20) check("a_release_bound", 1'b1, 1'b0);
  endtask

  task automatic a_run_to(input int target);
    int guard = 0;
    while (a_cnt != 32'(target) && guard < 600) begin step(); guard++; end
    if (guard >= 600) check("a_count_bound", 1'b1, 1'b0);
  endtask

  // One run on B: checks the staggered release edge by edge, then drives
  // one-cycle halt pulses at the given RUN cycle numbers and an optional abort.
  task automatic run_b(input int h0, input int h1, input int h2, input int h3,
                       input int ab_at, output int len);
    int h[4];
    int k;
    logic [3:0] exp_cr;
    h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
    b_start = 1; step(); b_start = 0;
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) step();
      // After edge n the hold count is n-1; core i leaves reset at 2+i.
      for (int i = 0; i < 4; i++) exp_cr[i] = ((n - 1) < (2 + i));
      check("b_core_rst_release", b_core_rst, exp_cr);
      check("b_running_release", b_running, (n == 6));
    end
    k = 0;
    while (b_running && k < 100) begin
      for (int i = 0; i < 4; i++) b_halt[i] = (h[i] == k);
      b_abort = (ab_at == k);
      step();
      k++;
    end
    b_halt = '0; b_abort = 0;
    if (k >= 100) check("b_run_bound", 1'b1, 1'b0);
    len = k;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, len, h[4], ab_at, allh, exp_len, exp_cnt, last;
    logic exp_to, exp_ab;
    logic [3:0] exp_hs;

    clear_inputs();
    rst = 1;
    repeat (3) step();
    check("rst_a_core_rst", a_core_rst, 1'b1);
    check("rst_a_flags", {a_running, a_done, a_to, a_ab, a_hs}, 5'b0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_b_core_rst", b_core_rst, 4'hf);
    check("rst_b_flags", {b_running, b_done, b_to, b_ab, b_hs}, 8'b0);
    check("rst_c_all", {c_core_rst, c_running, c_done, c_cnt}, 7'b1000000);
    rst = 0;
    repeat (5) step();
    check("idle_a_hold", {a_core_rst, a_running, a_done, a_to, a_ab, a_hs}, 6'b100000);
    check("idle_a_cnt", a_cnt, 0);
    check("idle_b_hold", {b_core_rst, b_running, b_done}, 6'b111100);

    // Single-cycle vectors on A.
    //            st ab h  cr run dn abd hs cnt
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0)); // Start -> RESET
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0)); // third edge: released, RUN
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 2)); // halt -> DONE, cycle counted
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 2)); // DONE holds
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 2)); // Abort in DONE ignored
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0)); // Start beats Abort in DONE
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 0)); // Abort in RESET
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 0)); // Abort in first RUN cycle
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0)); // halt while in reset ignored
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 1));
    for (int v = 0; v < vecs.size(); v++) begin
      a_start = vecs[v].start; a_abort = vecs[v].abort; a_halt = vecs[v].halt;
      step();
      check($sformatf("vec%0d_core_rst", v), a_core_rst, vecs[v].core_rst);
      check($sformatf("vec%0d_state", v), {a_running, a_done}, {vecs[v].running, vecs[v].done});
      check($sformatf("vec%0d_flags", v), {a_ab, a_to, a_hs}, {vecs[v].aborted, 1'b0, vecs[v].hs});
      check($sformatf("vec%0d_cnt", v), a_cnt, vecs[v].cnt);
    end
    clear_inputs();

    // Halt at RUN cycle 10.
    a_start_run(edges);
    check("a_release_edges", edges, 3);
    a_run_to(10);
    a_halt = 1; step(); a_halt = 0;
    check("halt10_done", {a_done, a_running}, 2'b10);
    check("halt10_cnt", a_cnt, 11);
    check("halt10_flags", {a_to, a_ab, a_core_rst}, 3'b001);

    // Budget expiry: exactly 400 RUN cycles.
    a_start_run(edges);
    len = 0;
    while (a_running && len < 500) begin step(); len++; end
    check("timeout_run_cycles", len, 400);
    check("timeout_cnt", a_cnt, 400);
    check("timeout_flags", {a_done, a_to, a_ab, a_core_rst}, 4'b1101);

    // Abort at RUN cycle 5.
    a_start_run(edges);
    a_run_to(5);
    a_abort = 1; step(); a_abort = 0;
    check("abort5_cnt", a_cnt, 5);
    check("abort5_flags", {a_done, a_ab, a_to, a_core_rst}, 4'b1101);

    // Abort together with all-halt: abort takes priority.
    a_start_run(edges);
    a_run_to(3);
    a_abort = 1; a_halt = 1; step(); a_abort = 0; a_halt = 0;
    check("abort_halt_flags", {a_done, a_ab, a_to}, 3'b110);
    check("abort_halt_cnt", a_cnt, 3);

    // Staggered release, halts on cores 0..3 at cycles 7, 15, 2, 11.
    run_b(7, 15, 2, 11, NEVER, len);
    check("stagger_len", len, 16);
    check("stagger_cnt", b_cnt, 16);
    check("stagger_hs", b_hs, 4'hf);
    check("stagger_flags", {b_done, b_to, b_ab, b_core_rst}, 7'b1001111);

    // Saturation on a 4-bit counter with no budget, then Rst mid-RUN.
    c_start = 1; step(); c_start = 0;
    len = 0;
    while (!c_running && len < 20) begin step(); len++; end
    check("c_enter_run", c_running, 1'b1);
    repeat (25) step();
    check("c_saturate_cnt", c_cnt, 4'hf);
    check("c_still_running", {c_running, c_to}, 2'b10);
    rst = 1; step();
    check("c_midrun_rst", {c_core_rst, c_running, c_done, c_to, c_ab, c_hs, c_cnt}, 10'b1000000000);
    rst = 0; step();
    check("c_after_rst_idle", {c_core_rst, c_running, c_done}, 3'b100);

    // Randomized runs on B against an outcome model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++)
        h[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 70));
      ab_at = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(0, 70));
      allh = 0;
      for (int i = 0; i < 4; i++) if (h[i] > allh) allh = h[i];
      exp_to = 0; exp_ab = 0;
      if (ab_at <= allh && ab_at <= TO_B - 1) begin
        exp_ab = 1; exp_len = ab_at + 1; exp_cnt = ab_at;
      end else if (allh <= TO_B - 1) begin
        exp_len = allh + 1; exp_cnt = allh + 1;
      end else begin
        exp_to = 1; exp_len = TO_B; exp_cnt = TO_B;
      end
      last = exp_len - 1;
      for (int i = 0; i < 4; i++) exp_hs[i] = (h[i] <= last);
      run_b(h[0], h[1], h[2], h[3], ab_at, len);
      check($sformatf("rand%0d_len", r), len, exp_len);
      check($sformatf("rand%0d_cnt", r), b_cnt, exp_cnt);
      check($sformatf("rand%0d_flags", r), {b_done, b_to, b_ab}, {1'b1, exp_to, exp_ab});
      check($sformatf("rand%0d_hs", r), b_hs, exp_hs);
      check($sformatf("rand%0d_core_rst", r), b_core_rst, 4'hf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
